// File: rtl/mem_arbiter_if.sv
// Bundle between the two requesters, the arbiter and the single-port RAM.
interface mem_arbiter_if #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 9,
    parameter int RAM_ADDR_WIDTH = 8
);
    // Handshake: reqX is held (with cmdX/addrX/wdataX) until doneX; doneX is a
    // one-cycle pulse with rdata valid, and the requester drops reqX after it.
    logic                      req0, req1;
    logic [1:0]                cmd0, cmd1;
    logic [ADDR_WIDTH-1:0]     addr0, addr1;
    logic [DATA_WIDTH-1:0]     wdata0, wdata1;
    logic                      gnt0, gnt1;
    logic                      done0, done1;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    logic                      ram_write;
    logic [DATA_WIDTH-1:0]     ram_din;
    logic [DATA_WIDTH-1:0]     ram_dout;

    modport slave (
        input  req0, req1, cmd0, cmd1, addr0, addr1, wdata0, wdata1, ram_dout,
        output gnt0, gnt1, done0, done1, rdata, ram_addr, ram_write, ram_din
    );

    modport master (
        output req0, req1, cmd0, cmd1, addr0, addr1, wdata0, wdata1, ram_dout,
        input  gnt0, gnt1, done0, done1, rdata, ram_addr, ram_write, ram_din
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between CPU (port 0)
// and loader (port 1); addresses with the MSB set are off-RAM and never touch it.
module mem_arbiter #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 9,
    parameter int RAM_ADDR_WIDTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus,
    output logic [1:0]   dbg_state
);
    localparam logic [1:0] MREAD  = 2'b11;
    localparam logic [1:0] MWRITE = 2'b01;

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RDWAIT = 2'd2, DONE = 2'd3} state_t;

    state_t                    state;
    logic                      last_gnt;
    logic                      port_q;
    logic                      rd_q;
    logic                      off_q;
    logic                      gnt0_q, gnt1_q, done0_q, done1_q, ram_write_q;
    logic [DATA_WIDTH-1:0]     rdata_q, ram_din_q;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr_q;

    logic                      any_req;
    logic                      pick1;
    logic [1:0]                w_cmd;
    logic [ADDR_WIDTH-1:0]     w_addr;
    logic [DATA_WIDTH-1:0]     w_wdata;

    // On a tie the port that did not win last time gets the RAM.
    assign any_req = bus.req0 | bus.req1;
    assign pick1   = bus.req1 & (~bus.req0 | ~last_gnt);
    assign w_cmd   = pick1 ? bus.cmd1   : bus.cmd0;
    assign w_addr  = pick1 ? bus.addr1  : bus.addr0;
    assign w_wdata = pick1 ? bus.wdata1 : bus.wdata0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_gnt    <= 1'b1;
            port_q      <= 1'b0;
            rd_q        <= 1'b0;
            off_q       <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            ram_write_q <= 1'b0;
            rdata_q     <= '0;
            ram_din_q   <= '0;
            ram_addr_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        port_q      <= pick1;
                        last_gnt    <= pick1;
                        gnt0_q      <= ~pick1;
                        gnt1_q      <= pick1;
                        ram_addr_q  <= w_addr[RAM_ADDR_WIDTH-1:0];
                        ram_din_q   <= w_wdata;
                        off_q       <= w_addr[ADDR_WIDTH-1];
                        rd_q        <= (w_cmd == MREAD);
                        // Strobe is registered so it is high for exactly the ACCESS cycle.
                        ram_write_q <= (w_cmd == MWRITE) & ~w_addr[ADDR_WIDTH-1];
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    ram_write_q <= 1'b0;
                    if (rd_q) begin
                        state <= RDWAIT;
                    end else begin
                        done0_q <= ~port_q;
                        done1_q <= port_q;
                        state   <= DONE;
                    end
                end
                RDWAIT: begin
                    rdata_q <= off_q ? '0 : bus.ram_dout;
                    done0_q <= ~port_q;
                    done1_q <= port_q;
                    state   <= DONE;
                end
                DONE: begin
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.rdata     = rdata_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_write = ram_write_q;
    assign bus.ram_din   = ram_din_q;
    assign dbg_state     = state;
endmodule
